// File: rtl/cell_comm_packet_receiver_pkg.sv
// Shared definitions for the cell packet receiver: header/final-word field
// layout, receive state encoding and the S-field sign extension helper.
package cell_comm_pkg;

  localparam logic [15:0] CELL_COMM_MAGIC = 16'hA5BE;
  localparam int          MAGIC_MSB       = 31;
  localparam int          MAGIC_LSB       = 16;

  localparam int INVALID_BIT = 31;
  localparam int CLIP_BIT    = 30;
  localparam int S_MSB       = 29;

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_X,
    ST_Y,
    ST_S,
    ST_DISCARD
  } rx_state_e;

  // The final word carries S as a 30-bit two's complement field.
  function automatic logic [31:0] sign_extend_s(input logic [31:0] w);
    return {{(31 - S_MSB){w[S_MSB]}}, w[S_MSB:0]};
  endfunction

endpackage

// File: rtl/cell_comm_packet_receiver_if.sv
// Aurora RX user stream into the receiver plus the accepted-sample strobe
// it produces for the readback/fast-feedback buffer.
interface cell_comm_packet_receiver_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int FOFB_IDX_WIDTH = 9
);

  logic                      rxValid;
  logic                      rxLast;
  logic [DATA_WIDTH-1:0]     rxData;
  logic                      rxFaStrobe;

  logic                      outValid;
  logic [FOFB_IDX_WIDTH-1:0] outIndex;
  logic [DATA_WIDTH-1:0]     outX;
  logic [DATA_WIDTH-1:0]     outY;
  logic [DATA_WIDTH-1:0]     outS;
  logic                      outClipping;

  modport master (
    output rxValid, rxLast, rxData, rxFaStrobe,
    input  outValid, outIndex, outX, outY, outS, outClipping
  );

  modport slave (
    input  rxValid, rxLast, rxData, rxFaStrobe,
    output outValid, outIndex, outX, outY, outS, outClipping
  );

endinterface

// File: rtl/cell_comm_packet_receiver_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cell_comm_packet_receiver.sv
// Receive-side framer for 4-word cell packets: validates each packet, emits
// accepted samples as one-cycle strobes and keeps per-FA-cycle statistics.
module cell_comm_packet_receiver
  import cell_comm_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FOFB_IDX_WIDTH = 9,
  parameter int GAP_TIMEOUT    = 63,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      rxClk,
  input  logic                      rxResetn,
  cell_comm_packet_receiver_if.slave rx,
  output logic [FOFB_IDX_WIDTH:0]   cellCount,
  output logic [FOFB_IDX_WIDTH:0]   cellCountLast,
  output logic [CNT_WIDTH-1:0]      goodCount,
  output logic [CNT_WIDTH-1:0]      badHeaderCount,
  output logic [CNT_WIDTH-1:0]      badLengthCount,
  output logic [CNT_WIDTH-1:0]      badCrcCount,
  output logic [CNT_WIDTH-1:0]      dupCount
);

  localparam int NUM_CELLS = 2 ** FOFB_IDX_WIDTH;
  localparam int GAP_W     = $clog2(GAP_TIMEOUT + 1);

  rx_state_e                 r_state;
  logic [GAP_W-1:0]          r_gap;
  logic [FOFB_IDX_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0]     r_x;
  logic [DATA_WIDTH-1:0]     r_y;
  logic [NUM_CELLS-1:0]      r_bitmap;
  logic [FOFB_IDX_WIDTH:0]   r_cell_count;
  logic [FOFB_IDX_WIDTH:0]   r_cell_last;

  logic                      r_out_valid;
  logic [FOFB_IDX_WIDTH-1:0] r_out_index;
  logic [DATA_WIDTH-1:0]     r_out_x;
  logic [DATA_WIDTH-1:0]     r_out_y;
  logic [DATA_WIDTH-1:0]     r_out_s;
  logic                      r_out_clip;

  logic                      w_hdr_ok;
  logic                      w_in_pkt;
  logic [GAP_W-1:0]          w_gap_next;
  logic                      w_timeout;
  logic                      w_final_ok;
  logic                      w_seen;
  logic [NUM_CELLS-1:0]      w_bitmap_eff;
  logic [FOFB_IDX_WIDTH:0]   w_cell_base;
  logic                      w_inc_good;
  logic                      w_inc_hdr;
  logic                      w_inc_len;
  logic                      w_inc_crc;
  logic                      w_inc_dup;

  // An FA strobe on the final word clears first, so the packet is judged
  // against an empty bitmap and lands in the new cycle.
  assign w_bitmap_eff = rx.rxFaStrobe ? '0 : r_bitmap;
  assign w_cell_base  = rx.rxFaStrobe ? '0 : r_cell_count;
  assign w_gap_next   = r_gap + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_hdr_ok   = 1'b0;
    w_in_pkt   = 1'b0;
    w_timeout  = 1'b0;
    w_final_ok = 1'b0;
    w_seen     = 1'b0;
    w_inc_good = 1'b0;
    w_inc_hdr  = 1'b0;
    w_inc_len  = 1'b0;
    w_inc_crc  = 1'b0;
    w_inc_dup  = 1'b0;

    w_hdr_ok = (rx.rxData[MAGIC_MSB:MAGIC_LSB] == CELL_COMM_MAGIC) &&
               (rx.rxData[MAGIC_LSB-1:FOFB_IDX_WIDTH] == '0);
    w_in_pkt = (r_state != ST_HEADER);
    w_timeout = !rx.rxValid && w_in_pkt && (w_gap_next == GAP_W'(GAP_TIMEOUT));
    w_seen   = w_bitmap_eff[r_index];

    if (rx.rxValid) begin
      unique case (r_state)
        ST_HEADER: begin
          w_inc_hdr = !w_hdr_ok;
          w_inc_len = w_hdr_ok && rx.rxLast;
        end
        ST_X, ST_Y: w_inc_len = rx.rxLast;
        ST_S: begin
          w_inc_len  = !rx.rxLast;
          w_inc_crc  = rx.rxLast && rx.rxData[INVALID_BIT];
          w_final_ok = rx.rxLast && !rx.rxData[INVALID_BIT];
          w_inc_dup  = w_final_ok && w_seen;
          w_inc_good = w_final_ok && !w_seen;
        end
        default: ;
      endcase
    end else if (w_timeout && (r_state != ST_DISCARD)) begin
      w_inc_len = 1'b1;
    end
  end

  // NOTE: the seen-bitmap is flop-based and sits on the async reset so the
  // first FA cycle after reset starts with no cells recorded.
  always_ff @(posedge rxClk or negedge rxResetn) begin
    if (!rxResetn) begin
      r_state      <= ST_HEADER;
      r_gap        <= '0;
      r_index      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_bitmap     <= '0;
      r_cell_count <= '0;
      r_cell_last  <= '0;
      r_out_valid  <= 1'b0;
      r_out_index  <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_s      <= '0;
      r_out_clip   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      if (rx.rxFaStrobe) begin
        r_cell_last  <= r_cell_count;
        r_cell_count <= '0;
        r_bitmap     <= '0;
      end

      if (w_inc_good) begin
        r_bitmap[r_index] <= 1'b1;
        r_cell_count      <= w_cell_base + 1'b1;
        r_out_valid       <= 1'b1;
        r_out_index       <= r_index;
        r_out_x           <= r_x;
        r_out_y           <= r_y;
        r_out_s           <= sign_extend_s(rx.rxData);
        r_out_clip        <= rx.rxData[CLIP_BIT];
      end

      if (rx.rxValid) begin
        r_gap <= '0;
        unique case (r_state)
          ST_HEADER: begin
            if (w_hdr_ok && !rx.rxLast) begin
              r_index <= rx.rxData[FOFB_IDX_WIDTH-1:0];
              r_state <= ST_X;
            end else if (!w_hdr_ok && !rx.rxLast) begin
              r_state <= ST_DISCARD;
            end
          end
          ST_X: begin
            r_x     <= rx.rxData;
            r_state <= rx.rxLast ? ST_HEADER : ST_Y;
          end
          ST_Y: begin
            r_y     <= rx.rxData;
            r_state <= rx.rxLast ? ST_HEADER : ST_S;
          end
          ST_S:       r_state <= rx.rxLast ? ST_HEADER : ST_DISCARD;
          ST_DISCARD: if (rx.rxLast) r_state <= ST_HEADER;
          default:    r_state <= ST_HEADER;
        endcase
      end else if (w_in_pkt) begin
        if (w_timeout) begin
          r_state <= ST_HEADER;
          r_gap   <= '0;
        end else begin
          r_gap <= w_gap_next;
        end
      end
    end
  end

  assign rx.outValid    = r_out_valid;
  assign rx.outIndex    = r_out_index;
  assign rx.outX        = r_out_x;
  assign rx.outY        = r_out_y;
  assign rx.outS        = r_out_s;
  assign rx.outClipping = r_out_clip;
  assign cellCount      = r_cell_count;
  assign cellCountLast  = r_cell_last;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_good_cnt (
    .clk(rxClk), .rst_n(rxResetn), .i_inc(w_inc_good), .o_count(goodCount)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_hdr_cnt (
    .clk(rxClk), .rst_n(rxResetn), .i_inc(w_inc_hdr), .o_count(badHeaderCount)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_len_cnt (
    .clk(rxClk), .rst_n(rxResetn), .i_inc(w_inc_len), .o_count(badLengthCount)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bad_crc_cnt (
    .clk(rxClk), .rst_n(rxResetn), .i_inc(w_inc_crc), .o_count(badCrcCount)
  );
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_dup_cnt (
    .clk(rxClk), .rst_n(rxResetn), .i_inc(w_inc_dup), .o_count(dupCount)
  );

endmodule

// File: tb/tb_cell_comm_packet_receiver.sv
// Directed bench for the cell packet receiver; counters are built 4 bits
// wide so saturation is reachable in a handful of packets.
module tb_cell_comm_packet_receiver;

  localparam int DW = 32;
  localparam int IW = 9;
  localparam int CW = 4;

  logic rxClk    = 1'b0;
  logic rxResetn = 1'b0;

  cell_comm_packet_receiver_if #(.DATA_WIDTH(DW), .FOFB_IDX_WIDTH(IW)) bus ();

  logic [IW:0]   cellCount;
  logic [IW:0]   cellCountLast;
  logic [CW-1:0] goodCount;
  logic [CW-1:0] badHeaderCount;
  logic [CW-1:0] badLengthCount;
  logic [CW-1:0] badCrcCount;
  logic [CW-1:0] dupCount;

  int n_vec = 0;
  int n_err = 0;

  always #5 rxClk = ~rxClk;

  cell_comm_packet_receiver #(
    .DATA_WIDTH(DW), .FOFB_IDX_WIDTH(IW), .GAP_TIMEOUT(63), .CNT_WIDTH(CW)
  ) dut (
    .rxClk          (rxClk),
    .rxResetn       (rxResetn),
    .rx             (bus),
    .cellCount      (cellCount),
    .cellCountLast  (cellCountLast),
    .goodCount      (goodCount),
    .badHeaderCount (badHeaderCount),
    .badLengthCount (badLengthCount),
    .badCrcCount    (badCrcCount),
    .dupCount       (dupCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rxClk);
    #1;
  endtask

  task automatic word(input logic last, input logic [31:0] data, input logic fa = 1'b0);
    bus.rxValid    = 1'b1;
    bus.rxLast     = last;
    bus.rxData     = data;
    bus.rxFaStrobe = fa;
    step();
    bus.rxValid    = 1'b0;
    bus.rxLast     = 1'b0;
    bus.rxData     = '0;
    bus.rxFaStrobe = 1'b0;
  endtask

  task automatic pkt(input logic [31:0] h, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] s, input logic fa_last = 1'b0);
    word(1'b0, h);
    word(1'b0, x);
    word(1'b0, y);
    word(1'b1, s, fa_last);
  endtask

  initial begin
    bus.rxValid    = 1'b0;
    bus.rxLast     = 1'b0;
    bus.rxData     = '0;
    bus.rxFaStrobe = 1'b0;
    repeat (3) step();

    check("rst_out_valid", 32'(bus.outValid), 32'd0);
    check("rst_out_x", bus.outX, 32'd0);
    check("rst_cell_count", 32'(cellCount), 32'd0);
    check("rst_good", 32'(goodCount), 32'd0);
    rxResetn = 1'b1;
    step();

    // Basic accepted packet, clipping set, S positive
    pkt(32'hA5BE_0005, 32'd1, 32'd2, 32'h4000_0003);
    check("t1_valid", 32'(bus.outValid), 32'd1);
    check("t1_index", 32'(bus.outIndex), 32'd5);
    check("t1_x", bus.outX, 32'd1);
    check("t1_y", bus.outY, 32'd2);
    check("t1_s", bus.outS, 32'd3);
    check("t1_clip", 32'(bus.outClipping), 32'd1);
    check("t1_good", 32'(goodCount), 32'd1);
    check("t1_cells", 32'(cellCount), 32'd1);
    step();
    check("t1_valid_pulse", 32'(bus.outValid), 32'd0);

    // Bad header, then a good packet with negative S
    pkt(32'h1234_0005, 32'd1, 32'd2, 32'd3);
    check("t2_no_valid", 32'(bus.outValid), 32'd0);
    check("t2_bad_hdr", 32'(badHeaderCount), 32'd1);
    pkt(32'hA5BE_0006, 32'h11, 32'h22, 32'h2000_0000);
    check("t2_valid", 32'(bus.outValid), 32'd1);
    check("t2_s_sext", bus.outS, 32'hE000_0000);
    check("t2_clip", 32'(bus.outClipping), 32'd0);
    check("t2_cells", 32'(cellCount), 32'd2);

    // Short packet (last on Y), then a 5-word packet
    word(1'b0, 32'hA5BE_0008);
    word(1'b0, 32'h77);
    word(1'b1, 32'h78);
    check("t3_len1", 32'(badLengthCount), 32'd1);
    word(1'b0, 32'hA5BE_000A);
    word(1'b0, 32'h1);
    word(1'b0, 32'h2);
    word(1'b0, 32'h3);
    check("t3_len2", 32'(badLengthCount), 32'd2);
    word(1'b1, 32'h0);
    check("t3_discard_hdr", 32'(badHeaderCount), 32'd1);
    check("t3_discard_len", 32'(badLengthCount), 32'd2);
    pkt(32'hA5BE_0008, 32'h88, 32'h99, 32'h3FFF_FFFF);
    check("t3_valid", 32'(bus.outValid), 32'd1);
    check("t3_s_neg1", bus.outS, 32'hFFFF_FFFF);
    check("t3_good", 32'(goodCount), 32'd3);

    // Invalid flag and duplicate index
    pkt(32'hA5BE_000B, 32'h1, 32'h2, 32'h8000_0000);
    check("t4_crc", 32'(badCrcCount), 32'd1);
    check("t4_crc_no_valid", 32'(bus.outValid), 32'd0);
    pkt(32'hA5BE_0005, 32'h55, 32'h56, 32'h7);
    check("t4_dup", 32'(dupCount), 32'd1);
    check("t4_dup_no_valid", 32'(bus.outValid), 32'd0);
    check("t4_x_held", bus.outX, 32'h88);
    check("t4_good", 32'(goodCount), 32'd3);
    check("t4_cells", 32'(cellCount), 32'd3);

    // FA strobe on the final word of index 7
    pkt(32'hA5BE_0007, 32'h70, 32'h71, 32'h72, 1'b1);
    check("t5_last", 32'(cellCountLast), 32'd3);
    check("t5_cells", 32'(cellCount), 32'd1);
    check("t5_valid", 32'(bus.outValid), 32'd1);
    check("t5_index", 32'(bus.outIndex), 32'd7);
    pkt(32'hA5BE_0005, 32'h50, 32'h51, 32'h52);
    check("t5_reaccept", 32'(bus.outValid), 32'd1);
    check("t5_cells2", 32'(cellCount), 32'd2);

    // FA strobe while a packet is in flight
    word(1'b0, 32'hA5BE_000C);
    word(1'b0, 32'hC0, 1'b1);
    word(1'b0, 32'hC1);
    word(1'b1, 32'hC2);
    check("t6_valid", 32'(bus.outValid), 32'd1);
    check("t6_last", 32'(cellCountLast), 32'd2);
    check("t6_cells", 32'(cellCount), 32'd1);

    // Gap handling: short gap tolerated, long gap aborts
    word(1'b0, 32'hA5BE_000D);
    word(1'b0, 32'hD0);
    repeat (10) step();
    word(1'b0, 32'hD1);
    word(1'b1, 32'hD2);
    check("t7_short_gap", 32'(bus.outValid), 32'd1);
    word(1'b0, 32'hA5BE_000E);
    word(1'b0, 32'hE0);
    repeat (64) step();
    check("t7_timeout_len", 32'(badLengthCount), 32'd3);
    pkt(32'hA5BE_000E, 32'hE1, 32'hE2, 32'hE3);
    check("t7_after_timeout", 32'(bus.outValid), 32'd1);
    check("t7_x", bus.outX, 32'hE1);
    word(1'b0, 32'h1234_0000);
    repeat (64) step();
    pkt(32'hA5BE_000F, 32'hF1, 32'hF2, 32'hF3);
    check("t7_discard_to", 32'(bus.outValid), 32'd1);
    check("t7_discard_len", 32'(badLengthCount), 32'd3);
    check("t7_discard_hdr", 32'(badHeaderCount), 32'd2);
    check("t7_good", 32'(goodCount), 32'd9);
    check("t7_cells", 32'(cellCount), 32'd4);

    // Saturation of a 4-bit counter
    repeat (14) word(1'b1, 32'hA5BE_0001);
    check("t8_sat", 32'(badLengthCount), 32'd15);
    word(1'b1, 32'hA5BE_0001);
    check("t8_sat_hold", 32'(badLengthCount), 32'd15);
    check("t8_good_untouched", 32'(goodCount), 32'd9);

    // Asynchronous reset mid-packet
    word(1'b0, 32'hA5BE_0010);
    word(1'b0, 32'h100);
    rxResetn = 1'b0;
    #1;
    check("t9_x", bus.outX, 32'd0);
    check("t9_index", 32'(bus.outIndex), 32'd0);
    check("t9_good", 32'(goodCount), 32'd0);
    check("t9_len", 32'(badLengthCount), 32'd0);
    check("t9_cell_last", 32'(cellCountLast), 32'd0);
    step();
    rxResetn = 1'b1;
    step();
    pkt(32'hA5BE_0010, 32'h101, 32'h102, 32'h103);
    check("t9_after_valid", 32'(bus.outValid), 32'd1);
    check("t9_after_good", 32'(goodCount), 32'd1);
    check("t9_after_cells", 32'(cellCount), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cell_comm_packet_receiver.md
Name: cell_comm_packet_receiver

Overview:
Receive-side stage that consumes the Aurora RX user stream carrying 4-word cell packets: header {16'hA5BE, index}, X, Y, then {invalid, clipping, S[29:0]} with last. It validates framing, header, length, CRC flag and duplicates. Accepted packets are emitted as one-cycle FOFB sample strobes for the readback/fast-feedback buffer. It also keeps per-FA-cycle cell bookkeeping and saturating error counters for the register interface.

Parameters:
DATA_WIDTH, 32, stream word width (fixed 32; header layout depends on it)
FOFB_IDX_WIDTH, 9, cell index width; the seen-bitmap is 2**FOFB_IDX_WIDTH bits
GAP_TIMEOUT, 63, max idle cycles between words inside a packet before the packet is aborted
CNT_WIDTH, 16, width of each saturating statistics counter

Ports:
rxClk  in  1  receiver Aurora user clock; the only clock
rxResetn  in  1  asynchronous active-low reset
rxValid  in  1  stream word valid; no backpressure, every valid word is consumed
rxLast  in  1  final word of packet
rxData  in  DATA_WIDTH  stream word
rxFaStrobe  in  1  one-cycle pulse marking the start of a new FA cycle
outValid  out  1  one-cycle strobe, accepted packet
outIndex  out  FOFB_IDX_WIDTH  cell index from header
outX  out  DATA_WIDTH  X word
outY  out  DATA_WIDTH  Y word
outS  out  DATA_WIDTH  S, sign-extended from bit 29
outClipping  out  1  bit 30 of final word
cellCount  out  FOFB_IDX_WIDTH+1  distinct cells accepted in current FA cycle
cellCountLast  out  FOFB_IDX_WIDTH+1  cellCount latched at last rxFaStrobe
goodCount, badHeaderCount, badLengthCount, badCrcCount, dupCount  out  CNT_WIDTH each  saturating counters

Behaviour:
- Reset: all outputs 0, bitmap cleared, state HEADER, gap timer 0.
- States: HEADER, X, Y, S, DISCARD. Transitions occur only on cycles where rxValid=1, except for the gap timeout.
- HEADER: rxData[31:16]==16'hA5BE and rxData[15:FOFB_IDX_WIDTH]==0:
  - rxLast=1 -> badLength++, stay in HEADER.
  - Else latch the index and go to X.
  - Header mismatch: badHeader++; rxLast=1 -> stay in HEADER, else go to DISCARD.
- X, Y: latch the word.
  - rxLast=1 -> badLength++, go to HEADER.
  - Else advance X->Y->S.
- S:
  - rxLast=0 -> badLength++, go to DISCARD.
  - rxLast=1 with rxData[31]=1 -> badCrc++, go to HEADER, no output.
  - Otherwise, if the bitmap bit for the index is set -> dup++, no output.
  - Else set the bit, cellCount++, goodCount++, and assert outValid for the next cycle; outX/outY/outS/outIndex/outClipping are updated on the same edge and hold until the next accepted packet.
  - All S-state outcomes return to HEADER.
- DISCARD: drop words until rxLast=1, then go to HEADER; no additional counts.
- Latency: outValid is high exactly one cycle after the rxClk edge that consumed the final word. Back-to-back packets with no idle cycles are supported at full rate.
- Gap timer: reset on every valid word; counts idle cycles while in X/Y/S/DISCARD.
  - Reaching GAP_TIMEOUT in X/Y/S -> badLength++, go to HEADER.
  - Reaching it in DISCARD -> go to HEADER silently.
- rxFaStrobe: cellCountLast<=cellCount, cellCount<=0, bitmap cleared.
  - If it coincides with a packet's final word, the clear applies first. The packet is then judged against the empty bitmap and counts into the new cycle (cellCount=1).
  - A packet in flight across the strobe is not aborted.
- Counters saturate at all-ones. When several counters change in one cycle, each updates independently. cellCount cannot overflow (width FOFB_IDX_WIDTH+1).

Decomposition:
- Shared package cell_comm_pkg:
  - CELL_COMM_MAGIC=16'hA5BE
  - Header field positions: magic [31:16], index [FOFB_IDX_WIDTH-1:0]
  - Final-word bit positions: INVALID_BIT=31, CLIP_BIT=30, S_MSB=29
  - State enum
- Sub-module sat_counter (CNT_WIDTH, inc input, async active-low reset), instantiated once per statistic.

Test Plan:
- Good packet {A5BE0005, 1, 2, 0x4000_0003 last} -> one cycle later outValid=1, outIndex=5, X=1, Y=2, S=3, outClipping=1; goodCount=1, cellCount=1.
- Header 0x12340005 followed by 3 words, last on the 4th -> badHeaderCount=1, no outValid; the next good packet is accepted.
- Last asserted on the Y word -> badLengthCount=1, state HEADER; 5-word packet (last on 5th) -> badLengthCount=2, with the 5th word discarded.
- Final word 0x8000_0000 -> badCrcCount=1, no output. The same index sent twice -> dupCount=1, one outValid.
- rxFaStrobe coincident with the final word of index 7 after 3 cells -> cellCountLast=3, cellCount=1, outValid=1.
- Other cases:
  - Stall 64 idle cycles after X -> badLengthCount+1, state HEADER.
  - Preload the counter at all-ones -> it holds.
  - Assert rxResetn low mid-packet -> all outputs 0 immediately.
